// File: rtl/sumador_8_bits.sv
// Registered ripple-carry adder: {cout,s} <= a + b + cin, one add per cycle.
// Ports: clk, rst (sync, active-high), in_valid, a, b, cin -> s, cout, out_valid.
// Optional: define SUMADOR_OVF_EN to add the registered signed-overflow port ovf.
module sumador_8_bits #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
`ifdef SUMADOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] s_full;
  logic             c_full;

  // Carry walks bit by bit through a local variable, so the chain
  // stays a single combinational block instead of a looped vector.
  always_comb begin
    logic cy;
    cy     = cin;
    s_full = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s_full[i] = a[i] ^ b[i] ^ cy;
      cy = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_full = cy;
  end

  // Result registers load only on in_valid, so X on idle inputs
  // never reaches s/cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= s_full;
        cout <= c_full;
      end
    end
  end

`ifdef SUMADOR_OVF_EN
  logic ovf_full;

  // Same-sign operands producing an opposite-sign sum.
  assign ovf_full = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (s_full[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_full;
    end
  end
`endif

endmodule

// File: tb/tb_sumador_8_bits.sv
// Testbench for sumador_8_bits (WIDTH=7): vector table plus randomized
// traffic, expected results queued at drive time and checked one cycle later.
module tb_sumador_8_bits;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
  logic         out_valid;
`ifdef SUMADOR_OVF_EN
  logic         ovf;
`endif

  sumador_8_bits #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef SUMADOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] es;
    logic         ec;
    logic         ev;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         o;
    string        tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state for the hold behaviour and overflow flag.
  logic [W-1:0] m_s;
  logic         m_c;
  logic         m_o;

  function automatic logic sovf(logic [W-1:0] x, logic [W-1:0] y,
                                logic ci);
    int sx, sy, t;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    t  = sx + sy + int'(ci);
    return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
  endfunction

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    total++;
    if (s !== e.s) begin
      bad++;
      $display("FAIL %s s: got %0d want %0d", e.tag, s, e.s);
    end
    total++;
    if (cout !== e.c) begin
      bad++;
      $display("FAIL %s cout: got %0b want %0b", e.tag, cout, e.c);
    end
    total++;
    if (out_valid !== e.v) begin
      bad++;
      $display("FAIL %s out_valid: got %0b want %0b",
               e.tag, out_valid, e.v);
    end
`ifdef SUMADOR_OVF_EN
    total++;
    if (ovf !== e.o) begin
      bad++;
      $display("FAIL %s ovf: got %0b want %0b", e.tag, ovf, e.o);
    end
`endif
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    rst      = v.rst;
    in_valid = v.vld;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    if (v.rst) begin
      m_s = '0; m_c = 1'b0; m_o = 1'b0;
    end else if (v.vld) begin
      m_s = v.es; m_c = v.ec; m_o = sovf(v.a, v.b, v.cin);
    end
    e.s = v.es; e.c = v.ec; e.v = v.ev; e.o = m_o; e.tag = tag;
    q.push_back(e);
  endtask

  function automatic vec_t mk(logic r, logic vl, int x, int y, logic ci,
                              int es, logic ec, logic ev);
    vec_t v;
    v.rst = r; v.vld = vl;
    v.a = W'(x); v.b = W'(y); v.cin = ci;
    v.es = W'(es); v.ec = ec; v.ev = ev;
    return v;
  endfunction

  initial begin
    vec_t tbl[15];
    vec_t v;
    int   sum;

    tbl[0]  = mk(1, 0,   0,   0, 0,   0, 0, 0);
    tbl[1]  = mk(1, 0,   0,   0, 0,   0, 0, 0);
    tbl[2]  = mk(0, 1,   2,   1, 0,   3, 0, 1);
    tbl[3]  = mk(0, 1,  15,  15, 0,  30, 0, 1);
    tbl[4]  = mk(0, 1,  12,  30, 0,  42, 0, 1);
    tbl[5]  = mk(0, 1, 100,  15, 0, 115, 0, 1);
    tbl[6]  = mk(0, 1, 100, 116, 0,  88, 1, 1);
    tbl[7]  = mk(0, 1, 100,  73, 0,  45, 1, 1);
    tbl[8]  = mk(0, 1, 127, 127, 1, 127, 1, 1);
    tbl[9]  = mk(0, 1,   0,   0, 1,   1, 0, 1);
    tbl[10] = mk(0, 0,  55,  66, 1,   1, 0, 0);
    tbl[11] = mk(0, 0, 127, 127, 1,   1, 0, 0);
    tbl[12] = mk(1, 1,  10,  10, 0,   0, 0, 0);
    tbl[13] = mk(0, 1,   5,   5, 0,  10, 0, 1);
    tbl[14] = mk(0, 0,  90,  90, 1,  10, 0, 0);

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    m_s = '0; m_c = 1'b0; m_o = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_out();
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Random traffic: mostly valid back-to-back adds, some idles,
    // rare resets; expected values from an integer model.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_out();
      v.rst = ($urandom_range(0, 19) == 0);
      v.vld = ($urandom_range(0, 3) != 0);
      v.a   = W'($urandom_range(0, (1 << W) - 1));
      v.b   = W'($urandom_range(0, (1 << W) - 1));
      v.cin = 1'($urandom_range(0, 1));
      sum   = int'(v.a) + int'(v.b) + int'(v.cin);
      if (v.rst) begin
        v.es = '0; v.ec = 1'b0; v.ev = 1'b0;
      end else if (v.vld) begin
        v.es = W'(sum); v.ec = 1'(sum >> W); v.ev = 1'b1;
      end else begin
        v.es = m_s; v.ec = m_c; v.ev = 1'b0;
      end
      apply(v, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    check_out();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
